link_perf_monitor: RTL and testbench
====================================

// Module: link_perf_monitor
// PURPOSE
//  Parametrised, windowed traffic and credit monitor for NUM_LINKS switch-to-switch or endpoint
//  links in an N-node mesh testbench. Each link uses the credit/VC flow-control handshake.
//  Per link and per VC, the block tracks outstanding credits and flags protocol errors.
//  Per link, it counts transferred flits and stall cycles over a programmable measurement window.
// PARAMETERS
//  NUM_LINKS      8     number of monitored links
//  NUM_VCS        2     virtual channels per link
//  BUFFER_SIZE    8     downstream buffer depth per VC; initial credit count
//  CNT_WIDTH      16    width of flit/stall counters
//  WINDOW_CYCLES  1024  measurement window length in cycles, >=1
//  (derived) VC_W = max(1,$clog2(NUM_VCS)); CRED_W = $clog2(BUFFER_SIZE+1)
// PORTS
//  clk            in   1                       clock
//  n_rst          in   1                       asynchronous active-low reset
//  start          in   1                       pulse: begin a measurement window
//  clear          in   1                       pulse: abort window, zero stats and errors
//  link_valid     in   NUM_LINKS               per link: sender has a flit (data_ready)
//  link_accept    in   NUM_LINKS               per link: receiver took the flit (packet_sent)
//  link_vc        in   NUM_LINKS*VC_W          VC of the flit on each link
//  credit_return  in   NUM_LINKS*NUM_VCS       one-cycle pulse: one credit returned per link/VC
//  busy           out  1                       high in MEASURE
//  done           out  1                       high in DONE
//  flit_count     out  NUM_LINKS*CNT_WIDTH     flits transferred in window
//  stall_count    out  NUM_LINKS*CNT_WIDTH     cycles with valid&!accept in window
//  credits        out  NUM_LINKS*NUM_VCS*CRED_W current credits per link/VC
//  credit_err     out  NUM_LINKS*NUM_VCS       sticky under/overflow flag
// BEHAVIOUR
//  Reset state: FSM=IDLE; busy=0; done=0; all counts=0; credit_err=0; credits=BUFFER_SIZE.
//  Transfer: on link L, xfer=link_valid[L]&link_accept[L], sampled at rising clk.
//  Stall: on link L, link_valid[L]&!link_accept[L].
//  Credit tracking is always active and does not depend on the window:
//   xfer on VC v: -1; credit_return[L][v]: +1; both in the same cycle: unchanged.
//   xfer while credits==0 (no return that cycle): set err, credits stay 0.
//   return while credits==BUFFER_SIZE (no xfer that cycle): set err, credits stay BUFFER_SIZE.
//   link_vc>=NUM_VCS with xfer: set err on VC NUM_VCS-1; credits unchanged.
//   Only n_rst reloads credits. clear does not reload credits.
//  FSM IDLE/MEASURE/DONE; registered outputs; busy=(MEASURE), done=(DONE):
//   IDLE    --start--> MEASURE: zero counts and window counter wcnt.
//   MEASURE: each cycle, accumulate flit/stall counts and increment wcnt.
//            The cycle with wcnt==WINDOW_CYCLES-1 is counted; FSM then enters DONE.
//            Exactly WINDOW_CYCLES cycles are counted.
//            start while in MEASURE is ignored.
//   DONE: counts frozen and held.
//         start -> MEASURE with counts zeroed (same as from IDLE).
//   clear in any state -> IDLE; zeroes counts, wcnt and credit_err.
//         clear has priority over start in the same cycle.
//  Counters saturate at 2**CNT_WIDTH-1 and never wrap.
//  Outputs update one cycle after the sampled event (registered, latency 1).
//  n_rst asserted mid-window: immediate return to the reset state; no partial results kept.
// TESTING
//  1 Reset, no traffic: credits all 8, err 0, busy/done 0; start -> busy next cycle;
//    after 1024 cycles done=1 and all counts 0.
//  2 Link 0: valid&accept on VC1 for 5 cycles, no returns
//    -> credits[0][1]=3, flit_count[0]=5 at done.
//    Then 3 credit_return pulses -> credits 6.
//  3 Link 2: 9 xfers on VC0 with no returns -> credits 0 after 8th, credit_err[2][0]=1 on 9th;
//    clear -> err 0, credits stay 0.
//  4 Link 1: xfer and credit_return on same VC in same cycle, repeated 20 cycles
//    -> credits stay 8, flit_count[1]=20.
//    valid&!accept 7 cycles -> stall_count[1]=7.
//  5 CNT_WIDTH=4, WINDOW_CYCLES=32, continuous xfer with matching returns -> flit_count saturates at 15.
//    start and clear in same cycle -> IDLE.
//  6 Assert n_rst at wcnt=500 with nonzero counts -> all outputs at reset values;
//    new start gives full 1024-cycle window.

Source files
------------

// File: rtl/link_perf_monitor.sv
// link_perf_monitor
// Windowed traffic and credit monitor for NUM_LINKS credit/VC flow-controlled
// links. Credit tracking per link/VC runs all the time. Flit and stall counts
// per link are collected only inside a measurement window of WINDOW_CYCLES
// cycles, under a small IDLE/MEASURE/DONE controller.
module link_perf_monitor #(
    parameter int NUM_LINKS     = 8,
    parameter int NUM_VCS       = 2,
    parameter int BUFFER_SIZE   = 8,
    parameter int CNT_WIDTH     = 16,
    parameter int WINDOW_CYCLES = 1024,
    localparam int VC_W         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int CRED_W       = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic                                 start,
    input  logic                                 clear,
    input  logic [NUM_LINKS-1:0]                 link_valid,
    input  logic [NUM_LINKS-1:0]                 link_accept,
    input  logic [NUM_LINKS*VC_W-1:0]            link_vc,
    input  logic [NUM_LINKS*NUM_VCS-1:0]         credit_return,
    output logic                                 busy,
    output logic                                 done,
    output logic [NUM_LINKS*CNT_WIDTH-1:0]       flit_count,
    output logic [NUM_LINKS*CNT_WIDTH-1:0]       stall_count,
    output logic [NUM_LINKS*NUM_VCS*CRED_W-1:0]  credits,
    output logic [NUM_LINKS*NUM_VCS-1:0]         credit_err
);

    localparam int                  WC_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WC_W-1:0]     WC_LAST = WC_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CRED_W-1:0]   CRED_FULL = CRED_W'(BUFFER_SIZE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    logic [NUM_LINKS-1:0] xfer;
    logic [NUM_LINKS-1:0] stall;

    assign xfer  = link_valid & link_accept;
    assign stall = link_valid & ~link_accept;

    // ------------------------------------------------------------------
    // Credit tracking, one counter and one sticky error flag per link/VC.
    // ------------------------------------------------------------------
    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_LINKS; gi++) begin : g_link
            logic [VC_W-1:0] vc_sel;
            logic            bad_vc;

            assign vc_sel = link_vc[gi*VC_W +: VC_W];
            // A transfer tagged with a non-existent VC is charged to the last VC as an error.
            assign bad_vc = xfer[gi] && (int'(vc_sel) >= NUM_VCS);

            for (gj = 0; gj < NUM_VCS; gj++) begin : g_vc
                logic              take;
                logic              give;
                logic              err_set;
                logic              err_q, err_d;
                logic [CRED_W-1:0] cred_q, cred_d;

                // Next credit value and error condition for this link/VC.
                always_comb begin
                    take    = xfer[gi] && (vc_sel == VC_W'(gj));
                    give    = credit_return[gi*NUM_VCS + gj];
                    cred_d  = cred_q;
                    err_set = 1'b0;
                    if (take && !give) begin
                        if (cred_q == '0) begin
                            err_set = 1'b1;
                        end else begin
                            cred_d = cred_q - CRED_W'(1);
                        end
                    end else if (give && !take) begin
                        if (cred_q == CRED_FULL) begin
                            err_set = 1'b1;
                        end else begin
                            cred_d = cred_q + CRED_W'(1);
                        end
                    end
                    if (bad_vc && (gj == NUM_VCS - 1)) begin
                        err_set = 1'b1;
                    end
                    err_d = clear ? 1'b0 : (err_q | err_set);
                end

                // Credits reload only on reset; errors are also cleared by clear.
                always_ff @(posedge clk or negedge n_rst) begin
                    if (!n_rst) begin
                        cred_q <= CRED_FULL;
                        err_q  <= 1'b0;
                    end else begin
                        cred_q <= cred_d;
                        err_q  <= err_d;
                    end
                end

                assign credits[(gi*NUM_VCS + gj)*CRED_W +: CRED_W] = cred_q;
                assign credit_err[gi*NUM_VCS + gj]                 = err_q;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Measurement window controller and saturating per-link counters.
    // ------------------------------------------------------------------
    state_t               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WC_W-1:0]      wcnt_q;
    logic [CNT_WIDTH-1:0] flit_q  [NUM_LINKS];
    logic [CNT_WIDTH-1:0] stall_q [NUM_LINKS];

    // Window FSM with registered busy/done; counts accumulate only in MEASURE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wcnt_q  <= '0;
            for (int i = 0; i < NUM_LINKS; i++) begin
                flit_q[i]  <= '0;
                stall_q[i] <= '0;
            end
        end else if (clear) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wcnt_q  <= '0;
            for (int i = 0; i < NUM_LINKS; i++) begin
                flit_q[i]  <= '0;
                stall_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_MEASURE;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        wcnt_q  <= '0;
                        for (int i = 0; i < NUM_LINKS; i++) begin
                            flit_q[i]  <= '0;
                            stall_q[i] <= '0;
                        end
                    end
                end
                S_MEASURE: begin
                    for (int i = 0; i < NUM_LINKS; i++) begin
                        if (xfer[i] && (flit_q[i] != CNT_MAX)) begin
                            flit_q[i] <= flit_q[i] + CNT_WIDTH'(1);
                        end
                        if (stall[i] && (stall_q[i] != CNT_MAX)) begin
                            stall_q[i] <= stall_q[i] + CNT_WIDTH'(1);
                        end
                    end
                    if (wcnt_q == WC_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        wcnt_q  <= '0;
                    end else begin
                        wcnt_q <= wcnt_q + WC_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    generate
        for (gi = 0; gi < NUM_LINKS; gi++) begin : g_out
            assign flit_count[gi*CNT_WIDTH +: CNT_WIDTH]  = flit_q[gi];
            assign stall_count[gi*CNT_WIDTH +: CNT_WIDTH] = stall_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_link_perf_monitor.sv
// Directed bench for link_perf_monitor: a default-sized instance plus a
// 4-bit / 32-cycle instance for counter saturation. Link inputs are shared.
module tb_link_perf_monitor;

    localparam int NL = 8;
    localparam int NV = 2;
    localparam int CW = 4;   // credit width for BUFFER_SIZE=8

    logic                 clk = 1'b0;
    logic                 n_rst;
    logic                 start, clear, s_start, s_clear;
    logic [NL-1:0]        link_valid, link_accept;
    logic [NL-1:0]        link_vc;
    logic [NL*NV-1:0]     credit_return;

    logic                 busy, done, s_busy, s_done;
    logic [NL*16-1:0]     flit_count, stall_count;
    logic [NL*4-1:0]      s_flit_count, s_stall_count;
    logic [NL*NV*CW-1:0]  credits, s_credits;
    logic [NL*NV-1:0]     credit_err, s_credit_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    link_perf_monitor dut (
        .clk(clk), .n_rst(n_rst), .start(start), .clear(clear),
        .link_valid(link_valid), .link_accept(link_accept), .link_vc(link_vc),
        .credit_return(credit_return), .busy(busy), .done(done),
        .flit_count(flit_count), .stall_count(stall_count),
        .credits(credits), .credit_err(credit_err)
    );

    link_perf_monitor #(.CNT_WIDTH(4), .WINDOW_CYCLES(32)) dut_s (
        .clk(clk), .n_rst(n_rst), .start(s_start), .clear(s_clear),
        .link_valid(link_valid), .link_accept(link_accept), .link_vc(link_vc),
        .credit_return(credit_return), .busy(s_busy), .done(s_done),
        .flit_count(s_flit_count), .stall_count(s_stall_count),
        .credits(s_credits), .credit_err(s_credit_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] cred(input int l, input int v);
        return 64'(credits[(l*NV + v)*CW +: CW]);
    endfunction

    function automatic logic [63:0] flit(input int l);
        return 64'(flit_count[l*16 +: 16]);
    endfunction

    function automatic logic [63:0] stl(input int l);
        return 64'(stall_count[l*16 +: 16]);
    endfunction

    task automatic idle_links();
        link_valid    = '0;
        link_accept   = '0;
        link_vc       = '0;
        credit_return = '0;
    endtask

    initial begin
        n_rst = 1'b0;
        start = 1'b0; clear = 1'b0; s_start = 1'b0; s_clear = 1'b0;
        idle_links();
        tick(); tick();

        // ---- reset state ----
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_credits_all8", 64'(credits), {16{4'h8}});
        chk("rst_err", 64'(credit_err), 64'd0);
        chk("rst_flit_zero", 64'(flit_count == '0), 64'd1);
        n_rst = 1'b1;
        tick();

        // ---- 1: empty window of exactly 1024 cycles ----
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_busy_after_start", 64'(busy), 64'd1);
        repeat (1023) tick();
        chk("t1_busy_last_cycle", 64'(busy), 64'd1);
        chk("t1_not_done_yet", 64'(done), 64'd0);
        tick();
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_busy_low", 64'(busy), 64'd0);
        chk("t1_counts_zero", 64'((flit_count == '0) && (stall_count == '0)), 64'd1);

        // ---- 2: link 0 VC1, 5 transfers, then 3 returns ----
        start = 1'b1; tick(); start = 1'b0;
        link_valid[0] = 1'b1; link_accept[0] = 1'b1; link_vc[0] = 1'b1;
        repeat (5) tick();
        idle_links();
        chk("t2_cred01", cred(0, 1), 64'd3);
        chk("t2_cred00", cred(0, 0), 64'd8);
        begin
            int n = 0;
            while (!done && n < 2000) begin
                tick();
                n++;
            end
        end
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_flit0", flit(0), 64'd5);
        chk("t2_stall0", stl(0), 64'd0);
        credit_return[1] = 1'b1;
        repeat (3) tick();
        credit_return[1] = 1'b0;
        tick();
        chk("t2_cred01_after_ret", cred(0, 1), 64'd6);
        chk("t2_flit0_frozen", flit(0), 64'd5);

        // ---- 3: link 2 VC0 underflow, clear keeps credits ----
        link_valid[2] = 1'b1; link_accept[2] = 1'b1; link_vc[2] = 1'b0;
        repeat (8) tick();
        chk("t3_cred20_empty", cred(2, 0), 64'd0);
        chk("t3_err_not_yet", 64'(credit_err[4]), 64'd0);
        tick();
        idle_links();
        chk("t3_err_underflow", 64'(credit_err[4]), 64'd1);
        chk("t3_cred20_stays0", cred(2, 0), 64'd0);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t3_err_cleared", 64'(credit_err[4]), 64'd0);
        chk("t3_cred_kept", cred(2, 0), 64'd0);
        chk("t3_done_cleared", 64'(done), 64'd0);
        chk("t3_flit0_cleared", flit(0), 64'd0);
        // xfer and return together at zero credits: no change, no error
        link_valid[2] = 1'b1; link_accept[2] = 1'b1; credit_return[4] = 1'b1;
        tick();
        idle_links();
        chk("t3_both_at_zero_cred", cred(2, 0), 64'd0);
        chk("t3_both_at_zero_err", 64'(credit_err[4]), 64'd0);
        // return at full credits: overflow error, credits stay 8
        credit_return[7] = 1'b1;
        tick();
        idle_links();
        chk("t3_overflow_err", 64'(credit_err[7]), 64'd1);
        chk("t3_overflow_cred", cred(3, 1), 64'd8);

        // ---- 4: link 1 balanced traffic, then stalls ----
        start = 1'b1; tick(); start = 1'b0;
        link_valid[1] = 1'b1; link_accept[1] = 1'b1; link_vc[1] = 1'b0;
        credit_return[2] = 1'b1;
        repeat (20) tick();
        credit_return[2] = 1'b0; link_accept[1] = 1'b0;
        chk("t4_cred10", cred(1, 0), 64'd8);
        chk("t4_err10", 64'(credit_err[2]), 64'd0);
        repeat (7) tick();
        idle_links();
        chk("t4_flit1", flit(1), 64'd20);
        chk("t4_stall1", stl(1), 64'd7);
        chk("t4_busy", 64'(busy), 64'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t4_clear_idle", 64'(busy), 64'd0);
        chk("t4_clear_err7", 64'(credit_err[7]), 64'd0);

        // ---- 5: small instance saturation, start+clear priority ----
        link_valid[4] = 1'b1; link_accept[4] = 1'b1; link_vc[4] = 1'b0;
        credit_return[8] = 1'b1;
        s_start = 1'b1; tick(); s_start = 1'b0;
        chk("t5_s_busy", 64'(s_busy), 64'd1);
        repeat (15) tick();
        chk("t5_s_flit_15", 64'(s_flit_count[16 +: 4]), 64'd15);
        repeat (5) tick();
        chk("t5_s_flit_sat", 64'(s_flit_count[16 +: 4]), 64'd15);
        repeat (12) tick();
        chk("t5_s_done", 64'(s_done), 64'd1);
        chk("t5_s_flit_final", 64'(s_flit_count[16 +: 4]), 64'd15);
        idle_links();
        chk("t5_main_cred40", cred(4, 0), 64'd8);
        s_start = 1'b1; s_clear = 1'b1; tick(); s_start = 1'b0; s_clear = 1'b0;
        chk("t5_clear_wins_busy", 64'(s_busy), 64'd0);
        chk("t5_clear_wins_done", 64'(s_done), 64'd0);
        chk("t5_clear_zero", 64'(s_flit_count[16 +: 4]), 64'd0);

        // ---- 6: reset mid-window, then a full fresh window ----
        start = 1'b1; tick(); start = 1'b0;
        link_valid[5] = 1'b1; link_accept[5] = 1'b1; link_vc[5] = 1'b0;
        credit_return[10] = 1'b1;
        repeat (500) tick();
        chk("t6_flit5_pre", flit(5), 64'd500);
        n_rst = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_flit_zero", 64'(flit_count == '0), 64'd1);
        chk("t6_rst_cred20_reload", cred(2, 0), 64'd8);
        idle_links();
        tick();
        n_rst = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("t6_busy", 64'(busy), 64'd1);
        repeat (99) tick();
        start = 1'b1; tick(); start = 1'b0;   // ignored while measuring
        repeat (923) tick();
        chk("t6_busy_last_cycle", 64'(busy), 64'd1);
        tick();
        chk("t6_done_full_window", 64'(done), 64'd1);
        chk("t6_flit5_zero", flit(5), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
